// File: rtl/proj_minhash_sig.sv
// MinHash signature generator: sweeps the feature-map RAM once per start and keeps,
// per hash lane, the minimum hash over all addresses that hold nonzero data.
module proj_minhash_sig #(
    parameter int ENTRIES   = 32,
    parameter int DATA_BITS = 8,
    parameter int NUM_HASH  = 4,
    parameter int HASH_BITS = 16,
    localparam int ADDR_BITS = $clog2(ENTRIES)
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic                          in_start,
    output logic                          out_busy,
    output logic [ADDR_BITS-1:0]          out_ram_addr,
    output logic                          out_ram_we,
    input  logic [DATA_BITS-1:0]          in_ram_rdata,
    output logic                          out_sig_valid,
    input  logic                          in_sig_ready,
    output logic [NUM_HASH*HASH_BITS-1:0] out_sig,
    output logic                          out_empty
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        OUT
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ENTRIES - 1);

    state_t                 state;
    logic [ADDR_BITS-1:0]   addr;
    logic [ADDR_BITS-1:0]   addr_d;
    logic                   pending;
    logic                   empty_q;
    logic                   sig_valid_q;
    logic                   busy_q;
    logic [HASH_BITS-1:0]   min_q [NUM_HASH];
    logic [HASH_BITS-1:0]   hash  [NUM_HASH];
    logic [HASH_BITS-1:0]   addr_ext;

    // Hashes are computed for the address whose data is arriving this cycle.
    assign addr_ext = HASH_BITS'(addr_d);

    for (genvar k = 0; k < NUM_HASH; k++) begin : g_lane
        localparam logic [HASH_BITS-1:0] MUL = HASH_BITS'(2 * k + 1);
        localparam logic [HASH_BITS-1:0] ADD = HASH_BITS'(3 * k + 1);
        assign hash[k] = MUL * addr_ext + ADD;
        assign out_sig[k*HASH_BITS +: HASH_BITS] = min_q[k];
    end

    assign out_ram_addr  = addr;
    assign out_ram_we    = 1'b0;
    assign out_sig_valid = sig_valid_q;
    assign out_busy      = busy_q;
    assign out_empty     = empty_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= IDLE;
            addr        <= '0;
            addr_d      <= '0;
            pending     <= 1'b0;
            empty_q     <= 1'b1;
            sig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            // NOTE: the minima are plain flops, so they are reset here; an empty set must read as all-ones.
            for (int k = 0; k < NUM_HASH; k++) begin
                min_q[k] <= '1;
            end
        end else begin
            pending <= 1'b0;

            if (pending && in_ram_rdata != '0) begin
                empty_q <= 1'b0;
                for (int k = 0; k < NUM_HASH; k++) begin
                    if (hash[k] < min_q[k]) begin
                        min_q[k] <= hash[k];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (in_start) begin
                        state   <= READ;
                        addr    <= '0;
                        busy_q  <= 1'b1;
                        empty_q <= 1'b1;
                        for (int k = 0; k < NUM_HASH; k++) begin
                            min_q[k] <= '1;
                        end
                    end
                end
                READ: begin
                    pending <= 1'b1;
                    addr_d  <= addr;
                    if (addr == LAST_ADDR) begin
                        addr  <= '0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDR_BITS'(1);
                    end
                end
                DRAIN: begin
                    state       <= OUT;
                    sig_valid_q <= 1'b1;
                end
                OUT: begin
                    if (in_sig_ready) begin
                        state       <= IDLE;
                        sig_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_minhash_sig.sv
// Scoreboard bench for proj_minhash_sig: expected signatures are computed from the RAM
// image when start is driven and compared when the DUT presents its signature.
module tb_proj_minhash_sig;

    typedef logic [7:0] mem_t [32];
    typedef struct {
        logic [63:0] sig;
        logic        empty;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, ready_a = 1'b0;
    logic        start_b = 1'b0, ready_b = 1'b0;
    logic        busy_a, we_a, valid_a, empty_a;
    logic        busy_b, we_b, valid_b, empty_b;
    logic [4:0]  addr_a, addr_b;
    logic [7:0]  rdata_a, rdata_b;
    logic [63:0] sig_a;
    logic [19:0] sig_b;
    mem_t        mem_a, mem_b;
    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdata_a <= mem_a[addr_a];
    always @(posedge clk) rdata_b <= mem_b[addr_b];

    proj_minhash_sig dut_a (
        .in_clk(clk), .in_rst(rst), .in_start(start_a), .out_busy(busy_a),
        .out_ram_addr(addr_a), .out_ram_we(we_a), .in_ram_rdata(rdata_a),
        .out_sig_valid(valid_a), .in_sig_ready(ready_a), .out_sig(sig_a), .out_empty(empty_a)
    );

    proj_minhash_sig #(.HASH_BITS(5)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_start(start_b), .out_busy(busy_b),
        .out_ram_addr(addr_b), .out_ram_we(we_b), .in_ram_rdata(rdata_b),
        .out_sig_valid(valid_b), .in_sig_ready(ready_b), .out_sig(sig_b), .out_empty(empty_b)
    );

    function automatic exp_t model(input mem_t m, input int hb);
        exp_t e;
        int   mask;
        int   mn[4];
        int   h;
        mask = (1 << hb) - 1;
        e.empty = 1'b1;
        e.sig = '0;
        for (int k = 0; k < 4; k++) mn[k] = mask;
        for (int i = 0; i < 32; i++) begin
            if (m[i] != 8'h00) begin
                e.empty = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    h = ((2 * k + 1) * i + 3 * k + 1) & mask;
                    if (h < mn[k]) mn[k] = h;
                end
            end
        end
        for (int k = 0; k < 4; k++) e.sig = e.sig | (64'(mn[k]) << (k * hb));
        return e;
    endfunction

    // All tasks start and end at a falling edge.
    task automatic start_dut(input bit which);
        if (which) begin
            start_b = 1'b1;
            exp_q.push_back(model(mem_b, 5));
        end else begin
            start_a = 1'b1;
            exp_q.push_back(model(mem_a, 16));
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_valid(input bit which, output bit ok, output int lat);
        int c0;
        c0 = cyc;
        ok = 1'b0;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            if ((which ? valid_b : valid_a) === 1'b1) begin
                ok = 1'b1;
                lat = cyc - c0 + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handoff(input bit which);
        if (which) ready_b = 1'b1; else ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy_a, valid_a, we_a, addr_a} !== 8'h00) $display("FAIL reset_ctrl: busy/valid/we/addr=%b required 0", {busy_a, valid_a, we_a, addr_a});
        else pass_cnt++;
        total_cnt++;
        if (sig_a !== '1 || empty_a !== 1'b1) $display("FAIL reset_sig: sig=%h empty=%b required all-ones/1", sig_a, empty_a);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        bit ok; int lat; exp_t e;
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        start_dut(0);
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || lat != 34) $display("FAIL empty_latency: got %0d cycles required 34", lat);
        else pass_cnt++;
        total_cnt++;
        if (sig_a !== e.sig || empty_a !== e.empty) $display("FAIL empty_sig: sig=%h empty=%b required %h/%b", sig_a, empty_a, e.sig, e.empty);
        else pass_cnt++;
        total_cnt++;
        if (sig_a !== 64'hFFFF_FFFF_FFFF_FFFF || empty_a !== 1'b1) $display("FAIL empty_const: sig=%h empty=%b required all-ones/1", sig_a, empty_a);
        else pass_cnt++;
        handoff(0);
        total_cnt++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL empty_handoff: valid=%b busy=%b required 0/0", valid_a, busy_a);
        else pass_cnt++;
    endtask

    task automatic test_single();
        bit ok; int lat; exp_t e;
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        mem_a[5] = 8'h01;
        start_dut(0);
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || sig_a !== e.sig || empty_a !== e.empty) $display("FAIL single_sig: sig=%h empty=%b required %h/%b", sig_a, empty_a, e.sig, e.empty);
        else pass_cnt++;
        total_cnt++;
        if (sig_a !== {16'd45, 16'd32, 16'd19, 16'd6}) $display("FAIL single_const: sig=%h required 002d00200013 0006", sig_a);
        else pass_cnt++;
        handoff(0);
    endtask

    task automatic test_two();
        bit ok; int lat; exp_t e;
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        mem_a[3] = 8'h40;
        mem_a[10] = 8'h80;
        start_dut(0);
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || sig_a !== e.sig || empty_a !== 1'b0) $display("FAIL two_sig: sig=%h empty=%b required %h/0", sig_a, empty_a, e.sig);
        else pass_cnt++;
        total_cnt++;
        if (sig_a !== {16'd31, 16'd22, 16'd13, 16'd4}) $display("FAIL two_const: sig=%h required lanes 4,13,22,31", sig_a);
        else pass_cnt++;
        handoff(0);
    endtask

    task automatic test_hash_wrap();
        bit ok; int lat; exp_t e;
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        mem_b[31] = 8'h01;
        start_dut(1);
        wait_valid(1, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || sig_b !== e.sig[19:0] || empty_b !== 1'b0) $display("FAIL wrap_sig: sig=%h empty=%b required %h/0", sig_b, empty_b, e.sig[19:0]);
        else pass_cnt++;
        total_cnt++;
        if (sig_b[19:15] !== 5'd3 || sig_b[4:0] !== 5'd0) $display("FAIL wrap_lanes: lane3=%0d lane0=%0d required 3/0", sig_b[19:15], sig_b[4:0]);
        else pass_cnt++;
        handoff(1);
    endtask

    task automatic test_stall_restart();
        bit ok; int lat; exp_t e; logic [4:0] a0; int errs;
        foreach (mem_a[i]) mem_a[i] = 8'($urandom_range(0, 255));
        start_dut(0);
        repeat (5) @(negedge clk);
        a0 = addr_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total_cnt++;
        if (addr_a !== a0 + 5'd1 || busy_a !== 1'b1) $display("FAIL start_in_read: addr=%0d busy=%b required %0d/1", addr_a, busy_a, a0 + 5'd1);
        else pass_cnt++;
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        errs = ok ? 0 : 1;
        for (int n = 0; n < 10; n++) begin
            if (valid_a !== 1'b1 || sig_a !== e.sig || empty_a !== e.empty) errs++;
            start_a = (n == 4);
            @(negedge clk);
        end
        start_a = 1'b0;
        total_cnt++;
        if (errs != 0) $display("FAIL stall_stable: %0d bad cycles, last sig=%h required %h", errs, sig_a, e.sig);
        else pass_cnt++;
        total_cnt++;
        if (valid_a !== 1'b1 || sig_a !== e.sig) $display("FAIL start_in_out: valid=%b sig=%h required 1/%h", valid_a, sig_a, e.sig);
        else pass_cnt++;
        handoff(0);
        total_cnt++;
        if (valid_a !== 1'b0) $display("FAIL stall_handoff: valid=%b required 0", valid_a);
        else pass_cnt++;
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        mem_a[20] = 8'h11;
        start_dut(0);
        total_cnt++;
        if (busy_a !== 1'b1) $display("FAIL restart_busy: busy=%b required 1", busy_a);
        else pass_cnt++;
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || sig_a !== e.sig || empty_a !== e.empty) $display("FAIL restart_sig: sig=%h empty=%b required %h/%b", sig_a, empty_a, e.sig, e.empty);
        else pass_cnt++;
        handoff(0);
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; exp_t e; bit hit;
        foreach (mem_a[i]) mem_a[i] = (i % 3 == 0) ? 8'h01 : 8'h00;
        start_dut(0);
        hit = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (addr_a === 5'd12) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        void'(exp_q.pop_back());
        total_cnt++;
        if (!hit) $display("FAIL mid_reach: addr=%0d required 12", addr_a);
        else pass_cnt++;
        rst = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_a = 1'b0;
        total_cnt++;
        if ({busy_a, valid_a, addr_a} !== 7'h00 || sig_a !== '1 || empty_a !== 1'b1)
            $display("FAIL mid_reset: busy=%b valid=%b addr=%0d sig=%h empty=%b required reset values", busy_a, valid_a, addr_a, sig_a, empty_a);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy_a !== 1'b0) $display("FAIL mid_reset_start: busy=%b required 0", busy_a);
        else pass_cnt++;
        mem_a[0] = 8'h00;
        mem_a[7] = 8'h05;
        start_dut(0);
        wait_valid(0, ok, lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || sig_a !== e.sig || empty_a !== e.empty) $display("FAIL mid_fresh_sig: sig=%h empty=%b required %h/%b", sig_a, empty_a, e.sig, e.empty);
        else pass_cnt++;
        handoff(0);
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; exp_t e;
        ready_a = 1'b1;
        for (int r = 0; r < 2; r++) begin
            foreach (mem_a[i]) mem_a[i] = 8'h00;
            mem_a[r * 9 + 2] = 8'hA5;
            start_dut(0);
            wait_valid(0, ok, lat);
            e = exp_q.pop_front();
            total_cnt++;
            if (!ok || sig_a !== e.sig || empty_a !== e.empty) $display("FAIL b2b_sig%0d: sig=%h empty=%b required %h/%b", r, sig_a, empty_a, e.sig, e.empty);
            else pass_cnt++;
            @(negedge clk);
        end
        ready_a = 1'b0;
        total_cnt++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL b2b_idle: valid=%b busy=%b required 0/0", valid_a, busy_a);
        else pass_cnt++;
    endtask

    initial begin
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_empty();
        test_single();
        test_two();
        test_hash_wrap();
        test_stall_restart();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/proj_minhash_sig.md
Name: proj_minhash_sig

Overview:
- Downstream consumer of the feature-map RAM (registered read port, one-cycle read latency).
- On a start pulse, sweeps every RAM address once and treats each address holding nonzero data as a set element.
- For each of NUM_HASH hash functions, keeps the running minimum of that element's hash, then presents the finished signature on a valid/ready output.

Parameters:
- ENTRIES, 32, RAM depth; addresses 0..ENTRIES-1; ADDR_BITS = $clog2(ENTRIES).
- DATA_BITS, 8, RAM word width.
- NUM_HASH, 4, number of hash lanes.
- HASH_BITS, 16, width of each hash value and signature lane.

Ports:
- in_clk  input  1  clock, all logic on rising edge.
- in_rst  input  1  synchronous active-high reset.
- in_start  input  1  single-cycle start request.
- out_busy  output  1  high from the cycle after start is accepted until the signature is handed off.
- out_ram_addr  output  ADDR_BITS  RAM read address.
- out_ram_we  output  1  tied 0 (read only).
- in_ram_rdata  input  DATA_BITS  RAM read data, valid the cycle after the address.
- out_sig_valid  output  1  signature valid.
- in_sig_ready  input  1  downstream accepts signature.
- out_sig  output  NUM_HASH*HASH_BITS  lane k at bits [k*HASH_BITS +: HASH_BITS].
- out_empty  output  1  qualified by out_sig_valid; 1 when no nonzero entry was found.

Behaviour:
- Hash lane k for address i: h_k(i) = ((2k+1)*i + (3k+1)) mod 2^HASH_BITS.
  - Compute at HASH_BITS width.
  - Zero-extend i; truncate the product and the sum.
- FSM states: IDLE, READ, DRAIN, OUT.
- IDLE: out_ram_addr=0. in_start high moves to READ, clears every min register to all-ones and sets the empty flag to 1. in_start in any other state is ignored.
- READ: out_ram_addr counts 0..ENTRIES-1, one address per cycle. After presenting ENTRIES-1, go to DRAIN.
- Compare pipeline: a registered copy of the address plus a pending flag tracks each returned data word.
  - When the pending flag is set and in_ram_rdata != 0, each lane updates min_k <= min(min_k, h_k(addr_d)) and the empty flag clears.
  - Equal hash leaves min unchanged.
- DRAIN: one cycle to consume the last data word, then go to OUT.
- OUT: out_sig_valid=1; out_sig and out_empty stay stable until in_sig_ready=1 is sampled, then go to IDLE with valid=0 on the next cycle. ready=1 with valid=0 has no effect.
- Latency: start sampled at edge T; addresses appear in cycles T+1..T+ENTRIES; out_sig_valid rises at T+ENTRIES+2.
- Empty set: out_sig is all-ones in every lane and out_empty=1.
- out_busy=1 in READ, DRAIN and OUT.
- Reset (any state, including mid-sweep):
  - FSM returns to IDLE; out_sig_valid=0, out_busy=0, out_ram_addr=0.
  - Min registers are all-ones, out_empty=1, address and pending registers are 0.
  - Reset takes precedence over in_start in the same cycle.
- Restart: a start in the cycle immediately after the handoff (IDLE) is accepted; no stale minima carry over.

Test Plan:
- Defaults; RAM all zero; pulse start -> out_sig_valid rises exactly 34 cycles after the start edge; every lane 0xFFFF; out_empty=1.
- Only addr 5 nonzero (0x01) -> lanes {k0..k3} = {6, 19, 32, 45}; out_empty=0.
- Addr 3 and addr 10 nonzero -> lane0=4, lane1=13 (minimum of the two candidates); lane2=22, lane3=31.
- HASH_BITS=5, only addr 31 nonzero -> lane3 = (7*31+10) mod 32 = 3 (wrap-around); lane0=0.
- Hold in_sig_ready=0 for 10 cycles in OUT -> valid and sig stable; also pulse in_start during READ and OUT -> ignored. Raise ready -> valid falls next cycle; a new start is then accepted.
- Assert in_rst at address 12 of a sweep -> next cycle IDLE, all outputs at reset values. A fresh start then produces the correct signature for the current RAM contents.
